// File: rtl/sd_rx_pack_fifo.sv
// sd_rx_pack_fifo: packs IN_W-bit SD beats into OUT_W-bit tagged words and buffers them in a FWFT FIFO.
module sd_rx_pack_fifo #(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 32,
  parameter int ADR_W     = 3,
  parameter int AF_THRESH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    d,
  input  logic               wr,
  input  logic               big_endian,
  input  logic               flush,
  output logic [OUT_W-1:0]   q,
  output logic               q_partial,
  input  logic               rd,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic [ADR_W:0]     level,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);
  localparam int N  = OUT_W / IN_W;
  localparam int SW = N > 1 ? $clog2(N) : 1;
  logic [SW-1:0]    slot, lane;
  logic [OUT_W-1:0] asm_q, merged;
  logic             mode, lane_be, last, push;
  logic [ADR_W:0]   wptr, rptr;
  logic [OUT_W:0]   mem [2**ADR_W];
  // endianness is taken live on the first beat of a word, then from the latched mode
  always_comb begin
    lane_be = slot == '0 ? big_endian : mode;
    lane    = lane_be ? SW'(N-1) - slot : slot;
    merged  = asm_q | (wr ? OUT_W'(d) << (IN_W*lane) : '0);
    last    = wr && slot == SW'(N-1);
    push    = last || (flush && (wr || slot != '0));
  end
  assign empty       = wptr == rptr;
  assign full        = wptr[ADR_W-1:0] == rptr[ADR_W-1:0] && wptr[ADR_W] != rptr[ADR_W];
  assign level       = wptr - rptr;
  assign almost_full = level >= (ADR_W+1)'(AF_THRESH);
  assign q           = mem[rptr[ADR_W-1:0]][OUT_W-1:0];
  assign q_partial   = mem[rptr[ADR_W-1:0]][OUT_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot      <= '0;
      asm_q     <= '0;
      mode      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        slot  <= '0;
        asm_q <= '0;
      end else if (wr) begin
        slot  <= slot + SW'(1);
        asm_q <= merged;
      end
      if (wr && slot == '0) mode <= big_endian;
      if (push && !full) wptr <= wptr + (ADR_W+1)'(1);
      if (rd && !empty) rptr <= rptr + (ADR_W+1)'(1);
      overflow  <= (push && full) || (overflow && !clr_err);
      underflow <= (rd && empty) || (underflow && !clr_err);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[ADR_W-1:0]] <= {!last, merged};
endmodule

// File: tb/tb_sd_rx_pack_fifo.sv
// tb_sd_rx_pack_fifo: directed checks of packing, endianness latch, flush, fill/overflow, wrap and reset.
module tb_sd_rx_pack_fifo;
  logic        clk = 0, rst = 1, wr = 0, big_endian = 0, flush = 0, rd = 0, clr_err = 0;
  logic [3:0]  d = 0;
  logic [31:0] q;
  logic        q_partial, full, empty, almost_full, overflow, underflow;
  logic [3:0]  level;
  logic [31:0] exp_q [$];
  logic [31:0] word;
  int          n_chk = 0, n_pass = 0;

  sd_rx_pack_fifo #(.IN_W(4), .OUT_W(32), .ADR_W(3), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .big_endian(big_endian), .flush(flush),
    .q(q), .q_partial(q_partial), .rd(rd), .full(full), .empty(empty),
    .almost_full(almost_full), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr = 0; flush = 0; rd = 0; clr_err = 0;
  endtask

  task automatic beat(input logic [3:0] v);
    wr = 1; d = v;
    step();
  endtask

  task automatic push_word(input logic [31:0] w, input logic be);
    for (int j = 0; j < 8; j++) begin
      big_endian = be;
      beat(be ? w[4*(7-j) +: 4] : w[4*j +: 4]);
    end
    big_endian = 0;
  endtask

  task automatic pop_chk(input string tag);
    chk(tag, q, exp_q.pop_front());
    rd = 1;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_err", {overflow, underflow}, 0);

    for (int i = 1; i <= 7; i++) beat(4'(i));
    chk("no_prime_empty", empty, 1);
    beat(4'd8);
    chk("le_empty", empty, 0);
    chk("le_level", level, 1);
    chk("le_q", q, 32'h87654321);
    chk("le_tag", q_partial, 0);
    rd = 1; step();
    chk("le_popped", empty, 1);

    for (int i = 1; i <= 8; i++) begin
      big_endian = i <= 3;
      beat(4'(i));
    end
    big_endian = 0;
    chk("be_latch_q", q, 32'h12345678);
    rd = 1; step();

    beat(4'hA); beat(4'hB); beat(4'hC);
    flush = 1; step();
    chk("flush_q", q, 32'h00000CBA);
    chk("flush_tag", q_partial, 1);
    chk("flush_level", level, 1);
    push_word(32'h87654321, 0);
    chk("after_flush_level", level, 2);
    flush = 1; step();
    chk("idle_flush_level", level, 2);
    rd = 1; step();
    chk("second_q", q, 32'h87654321);
    chk("second_tag", q_partial, 0);
    rd = 1; step();
    beat(4'h1);
    wr = 1; d = 4'h2; flush = 1; step();
    chk("wr_flush_q", q, 32'h00000021);
    chk("wr_flush_tag", q_partial, 1);
    rd = 1; step();
    for (int i = 1; i <= 7; i++) beat(4'(i));
    wr = 1; d = 4'h8; flush = 1; step();
    chk("complete_flush_q", q, 32'h87654321);
    chk("complete_flush_tag", q_partial, 0);
    chk("complete_flush_level", level, 1);
    rd = 1; step();
    chk("drained", empty, 1);

    for (int w = 0; w < 8; w++) begin
      word = 32'h76543210 + 32'h01111111 * 32'(w);
      push_word(word, 0);
      exp_q.push_back(word);
      if (w == 4) chk("af_at5", almost_full, 0);
      if (w == 5) chk("af_at6", almost_full, 1);
    end
    chk("full", full, 1);
    chk("full_level", level, 8);
    push_word(32'hDEADBEEF, 0);
    chk("overflow", overflow, 1);
    chk("ovf_level", level, 8);
    for (int w = 0; w < 8; w++) pop_chk("fill_order");
    chk("fill_empty", empty, 1);
    chk("no_underflow_yet", underflow, 0);
    rd = 1; step();
    chk("underflow", underflow, 1);
    clr_err = 1; step();
    chk("clr_err", {overflow, underflow}, 0);

    for (int w = 0; w < 3; w++) begin
      word = 32'hC0FFEE00 + 32'(w);
      push_word(word, 0);
      exp_q.push_back(word);
    end
    word = 32'hA5A55A5A;
    for (int j = 0; j < 7; j++) beat(word[4*j +: 4]);
    chk("concur_q", q, exp_q.pop_front());
    wr = 1; d = word[31:28]; rd = 1; step();
    exp_q.push_back(word);
    chk("concur_level", level, 3);

    for (int w = 0; w < 40; w++) begin
      word = $urandom;
      for (int j = 0; j < 8; j++) begin
        wr = 1; d = word[4*j +: 4];
        if (!empty && $urandom_range(0, 1) == 1) begin
          chk("stream_q", q, exp_q.pop_front());
          rd = 1;
        end
        step();
      end
      exp_q.push_back(word);
    end
    for (int i = 0; i < 16 && !empty; i++) pop_chk("drain_q");
    chk("stream_empty", empty, 1);
    chk("stream_model_empty", exp_q.size(), 0);
    chk("stream_flags", {overflow, underflow}, 0);

    for (int i = 0; i < 5; i++) beat(4'hF);
    rst = 1; #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_level", level, 0);
    @(posedge clk); #1 rst = 0;
    push_word(32'h13579BDF, 0);
    chk("post_rst_q", q, 32'h13579BDF);
    chk("post_rst_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
